// File: rtl/nand_target_emu.sv
// rtl/nand_target_emu.sv - x8 ONFI-style NAND target emulator (device side)
// Optional NAND_EMU_ERR_INJECT_EN adds err_inject to force FAIL at program/erase confirm.
module nand_target_emu #(
   parameter int          PAGE_BYTES  = 64,
   parameter int          NUM_PAGES   = 16,
   parameter int          BUSY_CYCLES = 32,
   parameter int          RST_CYCLES  = 8,
   parameter logic [31:0] ID_WORD     = 32'h2CF18095
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       nand_cle,
   input  logic       nand_ale,
   input  logic       nand_nwe,
   input  logic       nand_nre,
   input  logic       nand_nce,
   input  logic       nand_nwp,
   output logic       nand_rnb,
   inout  wire [15:0] nand_data
`ifdef NAND_EMU_ERR_INJECT_EN
   ,
   input  logic       err_inject
`endif
);
   localparam int CW = $clog2(PAGE_BYTES);
   localparam int RW = $clog2(NUM_PAGES);
   localparam logic [CW:0] PB = (CW+1)'(PAGE_BYTES);
   localparam logic [7:0]  NP = 8'(NUM_PAGES);
   localparam logic [15:0] BC = 16'(BUSY_CYCLES);
   localparam logic [15:0] RC = 16'(RST_CYCLES);

   typedef enum logic [2:0] {IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, ID_OUT, STAT_OUT} state_t;
   typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;
   typedef enum logic [1:0] {ACT_NONE, ACT_READ, ACT_PROG, ACT_ERASE} act_t;

   logic [1:0] cle_q, ale_q, nwe_q, nre_q, nce_q, nwp_q;
   logic [7:0] d_q1, d_q2;
   logic       nwe_d, nre_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cle_q <= 2'b00; ale_q <= 2'b00;
         nwe_q <= 2'b11; nre_q <= 2'b11; nce_q <= 2'b11; nwp_q <= 2'b11;
         d_q1  <= 8'h00; d_q2  <= 8'h00;
         nwe_d <= 1'b1;  nre_d <= 1'b1;
      end else begin
         cle_q <= {cle_q[0], nand_cle};
         ale_q <= {ale_q[0], nand_ale};
         nwe_q <= {nwe_q[0], nand_nwe};
         nre_q <= {nre_q[0], nand_nre};
         nce_q <= {nce_q[0], nand_nce};
         nwp_q <= {nwp_q[0], nand_nwp};
         d_q1  <= nand_data[7:0];
         d_q2  <= d_q1;
         nwe_d <= nwe_q[1];
         nre_d <= nre_q[1];
      end
   end

   logic       scle, sale, snce, swp;
   logic [7:0] sdata;
   logic       latch, cmd_ev, addr_ev, data_ev, re_rise;
   assign scle    = cle_q[1];
   assign sale    = ale_q[1];
   assign snce    = nce_q[1];
   assign swp     = nwp_q[1];
   assign sdata   = d_q2;
   assign latch   = nwe_q[1] && !nwe_d && !snce;
   assign cmd_ev  = latch && scle && !sale;
   assign addr_ev = latch && sale && !scle;
   assign data_ev = latch && !scle && !sale;
   assign re_rise = nre_q[1] && !nre_d;

   state_t      state, state_nx, ret_state, ret_nx;
   op_t         op, op_nx;
   act_t        act, act_nx;
   logic [1:0]  acnt, acnt_nx, idx, idx_nx;
   logic [7:0]  col_lo, col_lo_nx, row, row_nx, dout_reg, dout_nx;
   logic [CW:0] ptr, ptr_nx;
   logic [15:0] busy_cnt, cnt_nx, col_full;
   logic        fail, fail_nx, buf_preset, buf_we;
   logic        busy, done, row_ok, bad;
   logic [RW-1:0] row_idx;
   logic [7:0]  status;

   logic [7:0] pbuf [PAGE_BYTES];
   logic [7:0] ram  [NUM_PAGES][PAGE_BYTES];

   assign busy    = (busy_cnt != 16'd0);
   assign done    = (busy_cnt == 16'd1);
   assign row_ok  = (row < NP);
   assign row_idx = RW'(row);
   assign status  = {swp, ~busy, ~busy, 4'b0000, fail};
`ifdef NAND_EMU_ERR_INJECT_EN
   assign bad = !swp || !row_ok || err_inject;
`else
   assign bad = !swp || !row_ok;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE; ret_state <= IDLE; op <= OP_READ; act <= ACT_NONE;
         acnt <= 2'd0; idx <= 2'd0; col_lo <= 8'h00; row <= 8'h00;
         ptr <= '0; busy_cnt <= 16'd0; fail <= 1'b0; dout_reg <= 8'hFF;
      end else begin
         state <= state_nx; ret_state <= ret_nx; op <= op_nx; act <= act_nx;
         acnt <= acnt_nx; idx <= idx_nx; col_lo <= col_lo_nx; row <= row_nx;
         ptr <= ptr_nx; busy_cnt <= cnt_nx; fail <= fail_nx; dout_reg <= dout_nx;
      end
   end

   always_comb begin
      state_nx = state; ret_nx = ret_state; op_nx = op; act_nx = act;
      acnt_nx = acnt; idx_nx = idx; col_lo_nx = col_lo; row_nx = row;
      ptr_nx = ptr; cnt_nx = busy_cnt; fail_nx = fail;
      buf_preset = 1'b0; buf_we = 1'b0;
      col_full = {sdata, col_lo};
      if (busy) cnt_nx = busy_cnt - 16'd1;
      // Completion lands in DATA_OUT/IDLE, or is parked in ret_state while polling status
      if (done) begin
         if (state == BUSY) state_nx = (act == ACT_READ) ? DATA_OUT : IDLE;
         else if (state == STAT_OUT && ret_state == BUSY) ret_nx = (act == ACT_READ) ? DATA_OUT : IDLE;
      end
      if (snce) begin
         state_nx = (state_nx == STAT_OUT) ? IDLE : (busy && !done) ? state_nx : IDLE;
         if (state_nx == BUSY) state_nx = IDLE;
      end else if (cmd_ev) begin
         if (sdata == 8'hFF) begin
            state_nx = BUSY; act_nx = ACT_NONE; cnt_nx = RC; fail_nx = 1'b0;
         end else if (sdata == 8'h70) begin
            if (state != STAT_OUT) ret_nx = state;
            state_nx = STAT_OUT;
         end else if (busy) begin
            if (state == STAT_OUT) state_nx = ret_nx;
         end else if (state == STAT_OUT && sdata == 8'h00 &&
                      (ret_state == DATA_OUT || ret_state == ID_OUT)) begin
            state_nx = ret_state;
         end else begin
            case (sdata)
               8'h00: begin op_nx = OP_READ;  state_nx = ADDR; acnt_nx = 2'd0; end
               8'h90: begin op_nx = OP_ID;    state_nx = ADDR; acnt_nx = 2'd0; end
               8'h80: begin op_nx = OP_PROG;  state_nx = ADDR; acnt_nx = 2'd0;
                            fail_nx = 1'b0; buf_preset = 1'b1; ptr_nx = '0; end
               8'h60: begin op_nx = OP_ERASE; state_nx = ADDR; acnt_nx = 2'd0; fail_nx = 1'b0; end
               8'h30: begin
                  if (state == ADDR && op == OP_READ && acnt == 2'd3) begin
                     state_nx = BUSY; act_nx = ACT_READ; cnt_nx = BC;
                  end else state_nx = IDLE;
               end
               8'h10, 8'hD0: begin
                  if ((sdata == 8'h10 && op == OP_PROG &&
                       (state == DATA_IN || (state == ADDR && acnt == 2'd3))) ||
                      (sdata == 8'hD0 && op == OP_ERASE && state == ADDR && acnt != 2'd0)) begin
                     state_nx = BUSY; cnt_nx = BC;
                     if (bad) begin
                        fail_nx = 1'b1; act_nx = ACT_NONE;
                     end else act_nx = (op == OP_PROG) ? ACT_PROG : ACT_ERASE;
                  end else state_nx = IDLE;
               end
               default: state_nx = IDLE;
            endcase
         end
      end else if (addr_ev && state == ADDR) begin
         if (acnt != 2'd3) acnt_nx = acnt + 2'd1;
         case (op)
            OP_ID:    begin state_nx = ID_OUT; idx_nx = 2'd0; end
            OP_ERASE: if (acnt == 2'd0) row_nx = sdata;
            default: begin
               case (acnt)
                  2'd0: col_lo_nx = sdata;
                  2'd1: ptr_nx = {1'b0, CW'(col_full)};
                  2'd2: begin row_nx = sdata; if (op == OP_PROG) state_nx = DATA_IN; end
                  default: ;
               endcase
            end
         endcase
      end else if (data_ev && state == DATA_IN) begin
         if (ptr < PB) begin buf_we = 1'b1; ptr_nx = ptr + 1'b1; end
      end else if (re_rise) begin
         if (state == DATA_OUT && ptr < PB) ptr_nx = ptr + 1'b1;
         if (state == ID_OUT) idx_nx = idx + 2'd1;
      end
   end

   always_comb begin
      dout_nx = 8'hFF;
      case (state)
         DATA_OUT: dout_nx = (ptr < PB) ? pbuf[ptr[CW-1:0]] : 8'hFF;
         ID_OUT: begin
            case (idx)
               2'd0:    dout_nx = ID_WORD[31:24];
               2'd1:    dout_nx = ID_WORD[23:16];
               2'd2:    dout_nx = ID_WORD[15:8];
               default: dout_nx = ID_WORD[7:0];
            endcase
         end
         STAT_OUT: dout_nx = status;
         default: dout_nx = 8'hFF;
      endcase
   end

   // Array and page buffer are not reset; pages read undefined until erased
   always_ff @(posedge clk) begin
      if (buf_preset) begin
         for (int i = 0; i < PAGE_BYTES; i++) pbuf[i] <= 8'hFF;
      end else if (buf_we) begin
         pbuf[ptr[CW-1:0]] <= sdata;
      end
      if (done) begin
         case (act)
            ACT_READ:  for (int i = 0; i < PAGE_BYTES; i++) pbuf[i] <= row_ok ? ram[row_idx][i] : 8'hFF;
            ACT_PROG:  for (int i = 0; i < PAGE_BYTES; i++) ram[row_idx][i] <= ram[row_idx][i] & pbuf[i];
            ACT_ERASE: for (int i = 0; i < PAGE_BYTES; i++) ram[row_idx][i] <= 8'hFF;
            default: ;
         endcase
      end
   end

   assign nand_rnb        = !busy;
   assign nand_data[7:0]  = (resetn && !nand_nce && !nand_nre) ? dout_reg : 8'hzz;
   assign nand_data[15:8] = 8'hzz;
endmodule
